deadtime_gen_n: RTL and testbench
=================================

# deadtime_gen_n

Parametrised N-leg dead-time generator for the PWM modulator, sitting between the carrier comparator and the gate-driver pins. It turns one PWM command per inverter leg into a complementary high-side/low-side pair. High-side and low-side dead times are programmed separately, and any command pulse shorter than the dead time is swallowed. An optional latched fault shutdown forces every gate off.

## Interface
Parameters:
- NCH, 3, number of inverter legs (channels), ≥1
- CW, 16, dead-time counter and parameter width
- DT_RST, 50, reset value of both latched dead-time registers

Ports:
- CLK  in  1  system clock
- ARESETN  in  1  asynchronous active-low reset
- CARRIER_PEAK  in  1  single-cycle carrier-peak strobe; latches dead-time parameters
- LOAD  in  1  single-cycle forced parameter latch
- PRM_DT_HI  in  CW  dead cycles inserted before any high-side turn-on
- PRM_DT_LO  in  CW  dead cycles inserted before any low-side turn-on
- PWM_IN  in  NCH  per-leg command; 1 = high side, 0 = low side
- FAULT_N  in  1  active-low fault request (synchronous to CLK)
- FAULT_CLR  in  1  single-cycle fault-latch clear
- HI  out  NCH  high-side gate drives (registered)
- LO  out  NCH  low-side gate drives (registered)
- DT_ACTIVE  out  NCH  leg is currently in a dead interval
- FAULT_LATCHED  out  1  fault shutdown in force

## Operation
- Dead-time registers dt_hi and dt_lo:
  - Reset to DT_RST.
  - Load PRM_DT_HI and PRM_DT_LO on any cycle with CARRIER_PEAK|LOAD.
- Input stage: pwm_q[i] <= PWM_IN[i] every cycle. Reset value is 0.
- Per-leg FSM with states IDLE, DEAD_HI, HI_ON, DEAD_LO, LO_ON, plus counter cnt[CW-1:0]. Reset state is IDLE with cnt=0.
- Output decode:
  - HI = (state==HI_ON).
  - LO = (state==LO_ON).
  - DT_ACTIVE = (state==DEAD_HI or DEAD_LO).
  - All outputs are registered and reset to 0.
- IDLE:
  - pwm_q=1 enters DEAD_HI with cnt<=1.
  - pwm_q=0 enters DEAD_LO with cnt<=1.
  - A full dead time is therefore always enforced after reset or fault clear.
- LO_ON with pwm_q=1:
  - If dt_hi==0, go to HI_ON.
  - Otherwise go to DEAD_HI with cnt<=1.
- HI_ON with pwm_q=0: mirror of LO_ON, using dt_lo and DEAD_LO.
- DEAD_HI:
  - pwm_q=0 (abort) returns to LO_ON. The high side was never on, so this is safe, and the short pulse is swallowed.
  - Otherwise, if cnt>=dt_hi, go to HI_ON.
  - Otherwise cnt<=cnt+1.
- DEAD_LO: mirror of DEAD_HI, using dt_lo and HI_ON.
- The comparison is >=, so a dead time shortened mid-interval by a parameter latch ends immediately; it never wraps. The counter cannot overflow because cnt ≤ dt ≤ 2^CW-1.
- HI and LO are never 1 on the same leg in any cycle, for any parameter values.

## Timing
- PWM_IN edge sampled at edge n:
  - The conducting side drops after edge n+1.
  - The opposite side rises after edge n+1+DT, where DT is the dead time latched at that moment.
  - Exactly DT cycles have both sides low.
- With DT=0, the switchover happens at edge n+1 with no overlap cycle.
- Command pulse of width ≤ DT cycles: no turn-on of the pulsed side. The original side resumes one cycle after the pulse ends is sampled.
- Parameter latch takes effect on the next FSM evaluation. A simultaneous CARRIER_PEAK and LOAD is a single latch.
- Reset mid-operation: all outputs go to 0 asynchronously, and the FSM returns to IDLE.

## Configuration
- DEADTIME_FAULT_EN defined:
  - FAULT_N=0 sampled at edge n sets FAULT_LATCHED after edge n.
  - Every leg goes to IDLE with HI=LO=0 after edge n, overriding all other transitions.
  - Legs are held in IDLE while FAULT_LATCHED=1.
  - FAULT_CLR with FAULT_N=1 clears the latch at the next edge. Legs then restart from IDLE with a full dead time.
  - FAULT_CLR with FAULT_N=0 is ignored.
- DEADTIME_FAULT_EN undefined:
  - FAULT_N and FAULT_CLR are ignored.
  - FAULT_LATCHED is tied to 0.
  - No fault logic is synthesised.

## Test plan
- Reset release with PWM_IN=0 and DT_RST=50: LO[i] rises 50 cycles after the first post-reset edge; HI stays 0.
- dt_hi=10, dt_lo=5, PWM_IN[0] rising at edge n: LO[0] falls after n+1 and HI[0] rises after n+11. On the falling edge at m: HI[0] falls after m+1 and LO[0] rises after m+6.
- dt_hi=10 with a 6-cycle PWM_IN high pulse: HI never asserts, DT_ACTIVE asserts for 6 cycles, and LO returns.
- PRM_DT_HI changed from 20 to 3 with LOAD, 8 cycles into DEAD_HI: HI rises at the next FSM edge.
- Dead-time parameters set to 0: HI and LO toggle with a 1-cycle pipeline and are never both 1 (assertion checked every cycle, all legs).
- (DEADTIME_FAULT_EN) FAULT_N low while HI=1: all outputs are 0 next cycle. FAULT_CLR while FAULT_N=0 is ignored. FAULT_CLR after release gives a full dead time before any output reasserts.

Source files
------------

// File: rtl/deadtime_gen_n.sv
// N-leg complementary dead-time generator: one PWM command per leg in, HI/LO gate pair out.
// Optional latched fault shutdown is built only when DEADTIME_FAULT_EN is defined.
module deadtime_gen_n #(
    parameter int NCH    = 3,
    parameter int CW     = 16,
    parameter int DT_RST = 50
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_carrier_peak,
    input  logic           i_load,
    input  logic [CW-1:0]  i_prm_dt_hi,
    input  logic [CW-1:0]  i_prm_dt_lo,
    input  logic [NCH-1:0] i_pwm_in,
    input  logic           i_fault_n,
    input  logic           i_fault_clr,
    output logic [NCH-1:0] o_hi,
    output logic [NCH-1:0] o_lo,
    output logic [NCH-1:0] o_dt_active,
    output logic           o_fault_latched
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DEAD_HI,
        S_HI_ON,
        S_DEAD_LO,
        S_LO_ON
    } state_t;

    localparam logic [CW-1:0] LP_DT_RST = CW'(DT_RST);
    localparam logic [CW-1:0] LP_ONE    = CW'(1);

    logic [CW-1:0]  r_dt_hi;
    logic [CW-1:0]  r_dt_lo;
    logic [NCH-1:0] r_pwm_q;
    logic           w_force_idle;

    // Dead times latched at carrier peak or on demand; the FSM sees them one edge later.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_dt_hi <= LP_DT_RST;
            r_dt_lo <= LP_DT_RST;
        end else if (i_carrier_peak || i_load) begin
            r_dt_hi <= i_prm_dt_hi;
            r_dt_lo <= i_prm_dt_lo;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pwm_q <= '0;
        end else begin
            r_pwm_q <= i_pwm_in;
        end
    end

`ifdef DEADTIME_FAULT_EN
    logic r_fault;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fault <= 1'b0;
        end else if (!i_fault_n) begin
            r_fault <= 1'b1;
        end else if (i_fault_clr) begin
            r_fault <= 1'b0;
        end
    end

    assign w_force_idle    = !i_fault_n || r_fault;
    assign o_fault_latched = r_fault;
`else
    logic w_unused_fault;

    assign w_unused_fault  = i_fault_n ^ i_fault_clr;
    assign w_force_idle    = 1'b0;
    assign o_fault_latched = 1'b0;
`endif

    for (genvar g = 0; g < NCH; g++) begin : g_leg
        state_t        r_state;
        state_t        w_state_nxt;
        logic [CW-1:0] r_cnt;
        logic [CW-1:0] w_cnt_nxt;
        logic          r_hi;
        logic          r_lo;
        logic          r_dt_act;

        // An aborted dead interval falls back to the side that never switched off its partner.
        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            if (w_force_idle) begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        w_state_nxt = r_pwm_q[g] ? S_DEAD_HI : S_DEAD_LO;
                        w_cnt_nxt   = LP_ONE;
                    end
                    S_LO_ON: begin
                        if (r_pwm_q[g]) begin
                            if (r_dt_hi == '0) begin
                                w_state_nxt = S_HI_ON;
                            end else begin
                                w_state_nxt = S_DEAD_HI;
                                w_cnt_nxt   = LP_ONE;
                            end
                        end
                    end
                    S_HI_ON: begin
                        if (!r_pwm_q[g]) begin
                            if (r_dt_lo == '0) begin
                                w_state_nxt = S_LO_ON;
                            end else begin
                                w_state_nxt = S_DEAD_LO;
                                w_cnt_nxt   = LP_ONE;
                            end
                        end
                    end
                    S_DEAD_HI: begin
                        if (!r_pwm_q[g]) begin
                            w_state_nxt = S_LO_ON;
                        end else if (r_cnt >= r_dt_hi) begin
                            w_state_nxt = S_HI_ON;
                        end else begin
                            w_cnt_nxt = r_cnt + LP_ONE;
                        end
                    end
                    S_DEAD_LO: begin
                        if (r_pwm_q[g]) begin
                            w_state_nxt = S_HI_ON;
                        end else if (r_cnt >= r_dt_lo) begin
                            w_state_nxt = S_LO_ON;
                        end else begin
                            w_cnt_nxt = r_cnt + LP_ONE;
                        end
                    end
                    default: begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = '0;
                    end
                endcase
            end
        end

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_state  <= S_IDLE;
                r_cnt    <= '0;
                r_hi     <= 1'b0;
                r_lo     <= 1'b0;
                r_dt_act <= 1'b0;
            end else begin
                r_state  <= w_state_nxt;
                r_cnt    <= w_cnt_nxt;
                r_hi     <= (w_state_nxt == S_HI_ON);
                r_lo     <= (w_state_nxt == S_LO_ON);
                r_dt_act <= (w_state_nxt == S_DEAD_HI) || (w_state_nxt == S_DEAD_LO);
            end
        end

        assign o_hi[g]        = r_hi;
        assign o_lo[g]        = r_lo;
        assign o_dt_active[g] = r_dt_act;
    end

endmodule

// File: tb/tb_deadtime_gen_n.sv
// Randomised and directed bench for deadtime_gen_n against a timestamp-based reference model.
// Fault scenarios are exercised when DEADTIME_FAULT_EN is defined; otherwise fault inputs must be ignored.
module tb_deadtime_gen_n;

    localparam int NCH    = 3;
    localparam int CW     = 16;
    localparam int DT_RST = 50;

    logic           clk         = 1'b0;
    logic           rst_n       = 1'b0;
    logic           carrierPeak = 1'b0;
    logic           load        = 1'b0;
    logic [CW-1:0]  prmDtHi     = '0;
    logic [CW-1:0]  prmDtLo     = '0;
    logic [NCH-1:0] pwmIn       = '0;
    logic           faultN      = 1'b1;
    logic           faultClr    = 1'b0;
    logic [NCH-1:0] hi;
    logic [NCH-1:0] lo;
    logic [NCH-1:0] dtActive;
    logic           faultLatched;

    int checks    = 0;
    int passes    = 0;
    bit compareEn = 1'b0;

    // Reference: per leg, which side conducts (-1 none), which side a dead interval leads to, and when it began.
    int             mOn[NCH]    = '{default: -1};
    int             mTgt[NCH]   = '{default: -1};
    int             mStart[NCH] = '{default: 0};
    int             mDtHi       = DT_RST;
    int             mDtLo       = DT_RST;
    int             mNow        = 0;
    logic [NCH-1:0] mPwmQ       = '0;
    bit             mFault      = 1'b0;

    int             holdLeft[NCH] = '{default: 0};
    logic [NCH-1:0] cmd;

    deadtime_gen_n #(.NCH(NCH), .CW(CW), .DT_RST(DT_RST)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_carrier_peak (carrierPeak),
        .i_load         (load),
        .i_prm_dt_hi    (prmDtHi),
        .i_prm_dt_lo    (prmDtLo),
        .i_pwm_in       (pwmIn),
        .i_fault_n      (faultN),
        .i_fault_clr    (faultClr),
        .o_hi           (hi),
        .o_lo           (lo),
        .o_dt_active    (dtActive),
        .o_fault_latched(faultLatched)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin : refModel
        int on;
        int tgt;
        int c;
        int t;
        bit forceOff;
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                mOn[i]    <= -1;
                mTgt[i]   <= -1;
                mStart[i] <= 0;
            end
            mDtHi  <= DT_RST;
            mDtLo  <= DT_RST;
            mPwmQ  <= '0;
            mFault <= 1'b0;
            mNow   <= 0;
        end else begin
            t        = mNow + 1;
            forceOff = 1'b0;
`ifdef DEADTIME_FAULT_EN
            forceOff = !faultN || mFault;
`endif
            for (int i = 0; i < NCH; i++) begin
                on  = mOn[i];
                tgt = mTgt[i];
                c   = int'(mPwmQ[i]);
                if (forceOff) begin
                    on  = -1;
                    tgt = -1;
                end else if (tgt >= 0) begin
                    if (c != tgt) begin
                        on  = c;
                        tgt = -1;
                    end else if (t - mStart[i] >= (c == 1 ? mDtHi : mDtLo)) begin
                        on  = c;
                        tgt = -1;
                    end
                end else if (on != c) begin
                    if (on >= 0 && (c == 1 ? mDtHi : mDtLo) == 0) begin
                        on = c;
                    end else begin
                        tgt = c;
                        on  = -1;
                        mStart[i] <= t;
                    end
                end
                mOn[i]  <= on;
                mTgt[i] <= tgt;
            end
            if (carrierPeak || load) begin
                mDtHi <= int'(prmDtHi);
                mDtLo <= int'(prmDtLo);
            end
            mPwmQ <= pwmIn;
`ifdef DEADTIME_FAULT_EN
            if (!faultN) mFault <= 1'b1;
            else if (faultClr) mFault <= 1'b0;
`endif
            mNow <= t;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end else begin
            passes++;
        end
    endtask

    task automatic applyStimulus(input logic [NCH-1:0] pwm, input bit ld, input bit cp,
                                 input bit fN, input bit fClr);
        pwmIn       = pwm;
        load        = ld;
        carrierPeak = cp;
        faultN      = fN;
        faultClr    = fClr;
        @(negedge clk);
        load        = 1'b0;
        carrierPeak = 1'b0;
        faultClr    = 1'b0;
    endtask

    task automatic hold(input logic [NCH-1:0] pwm);
        applyStimulus(pwm, 1'b0, 1'b0, faultN, 1'b0);
    endtask

    // Every-cycle comparison against the reference, plus the never-both-on rule.
    always @(negedge clk) begin
        if (compareEn) begin
            for (int i = 0; i < NCH; i++) begin
                checkOutput($sformatf("hi[%0d]", i), 32'(hi[i]), 32'(mOn[i] == 1));
                checkOutput($sformatf("lo[%0d]", i), 32'(lo[i]), 32'(mOn[i] == 0));
                checkOutput($sformatf("dt_active[%0d]", i), 32'(dtActive[i]), 32'(mTgt[i] >= 0));
            end
            checkOutput("fault_latched", 32'(faultLatched), 32'(mFault));
            checkOutput("no_overlap", 32'(hi & lo), 32'd0);
        end
    end

    initial begin : stimulus
        int firstEvt;
        int secondEvt;
        int cnt;
        int sawHi;
        bit ld;
        bit cp;
        bit fN;
        bit fc;

        $display("[TB] start");
        repeat (3) @(negedge clk);
        checkOutput("reset_hi", 32'(hi), 32'd0);
        checkOutput("reset_lo", 32'(lo), 32'd0);
        checkOutput("reset_dt", 32'(dtActive), 32'd0);
        checkOutput("reset_fault", 32'(faultLatched), 32'd0);
        rst_n     = 1'b1;
        compareEn = 1'b1;

        firstEvt = -1;
        sawHi    = 0;
        for (int j = 1; j <= 60; j++) begin
            hold('0);
            if (firstEvt < 0 && lo == 3'b111) firstEvt = j;
            if (hi != 0) sawHi = 1;
        end
        checkOutput("reset_lo_rise_cycle", firstEvt, 51);
        checkOutput("reset_hi_stays_low", sawHi, 0);

        prmDtHi = 16'd10;
        prmDtLo = 16'd5;
        applyStimulus('0, 1'b1, 1'b0, 1'b1, 1'b0);
        firstEvt  = -1;
        secondEvt = -1;
        for (int j = 1; j <= 20; j++) begin
            hold(3'b001);
            if (firstEvt < 0 && lo[0] == 1'b0) firstEvt = j;
            if (secondEvt < 0 && hi[0] == 1'b1) secondEvt = j;
        end
        checkOutput("rise_lo_fall_cycle", firstEvt, 2);
        checkOutput("rise_hi_on_cycle", secondEvt, 12);
        firstEvt  = -1;
        secondEvt = -1;
        for (int j = 1; j <= 15; j++) begin
            hold(3'b000);
            if (firstEvt < 0 && hi[0] == 1'b0) firstEvt = j;
            if (secondEvt < 0 && lo[0] == 1'b1) secondEvt = j;
        end
        checkOutput("fall_hi_off_cycle", firstEvt, 2);
        checkOutput("fall_lo_on_cycle", secondEvt, 7);

        sawHi = 0;
        cnt   = 0;
        for (int j = 1; j <= 20; j++) begin
            hold(j <= 6 ? 3'b001 : 3'b000);
            if (hi[0]) sawHi = 1;
            if (dtActive[0]) cnt++;
        end
        checkOutput("short_pulse_no_hi", sawHi, 0);
        checkOutput("short_pulse_dt_cycles", cnt, 6);
        checkOutput("short_pulse_lo_back", 32'(lo[0]), 32'd1);

        prmDtHi = 16'd20;
        applyStimulus('0, 1'b1, 1'b0, 1'b1, 1'b0);
        repeat (9) hold(3'b001);
        checkOutput("shorten_in_dead", 32'(dtActive[0]), 32'd1);
        prmDtHi = 16'd3;
        applyStimulus(3'b001, 1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("shorten_latch_edge_hi", 32'(hi[0]), 32'd0);
        hold(3'b001);
        checkOutput("shorten_next_edge_hi", 32'(hi[0]), 32'd1);
        repeat (8) hold('0);

        prmDtHi = '0;
        prmDtLo = '0;
        applyStimulus('0, 1'b0, 1'b1, 1'b1, 1'b0);
        hold(3'b001);
        checkOutput("dt0_first_edge_lo", 32'(lo[0]), 32'd1);
        hold(3'b001);
        checkOutput("dt0_switch_hi", 32'(hi[0]), 32'd1);
        checkOutput("dt0_switch_lo", 32'(lo[0]), 32'd0);
        for (int j = 0; j < 200; j++) hold(NCH'($urandom_range(0, (1 << NCH) - 1)));

        prmDtHi = 16'd4;
        prmDtLo = 16'd4;
        applyStimulus('0, 1'b1, 1'b1, 1'b1, 1'b0);
        repeat (12) hold(3'b111);
        checkOutput("pre_reset_hi", 32'(hi), 32'h7);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_hi", 32'(hi), 32'd0);
        checkOutput("async_reset_dt", 32'(dtActive), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        prmDtHi = 16'd3;
        prmDtLo = 16'd3;
        applyStimulus('0, 1'b1, 1'b0, 1'b1, 1'b0);
        repeat (6) hold(3'b001);
        checkOutput("fault_pre_hi", 32'(hi[0]), 32'd1);
`ifdef DEADTIME_FAULT_EN
        applyStimulus(3'b001, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("fault_hi_off", 32'(hi), 32'd0);
        checkOutput("fault_lo_off", 32'(lo), 32'd0);
        checkOutput("fault_set", 32'(faultLatched), 32'd1);
        applyStimulus(3'b001, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("fault_clr_ignored", 32'(faultLatched), 32'd1);
        hold(3'b001);
        faultN = 1'b1;
        hold(3'b001);
        checkOutput("fault_held_after_release", 32'(faultLatched), 32'd1);
        applyStimulus(3'b001, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("fault_cleared", 32'(faultLatched), 32'd0);
        checkOutput("fault_clear_edge_idle", 32'(hi | lo | dtActive), 32'd0);
        firstEvt = -1;
        for (int j = 1; j <= 8; j++) begin
            hold(3'b001);
            if (firstEvt < 0 && (hi | lo) != 0) firstEvt = j;
        end
        checkOutput("fault_restart_cycle", firstEvt, 4);
        checkOutput("fault_restart_hi", 32'(hi), 32'h1);
`else
        applyStimulus(3'b001, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("fault_ignored_hi", 32'(hi[0]), 32'd1);
        checkOutput("fault_ignored_flag", 32'(faultLatched), 32'd0);
        applyStimulus(3'b001, 1'b0, 1'b0, 1'b1, 1'b0);
`endif

        cmd = pwmIn;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < NCH; i++) begin
                if (holdLeft[i] == 0) begin
                    cmd[i]      = ~cmd[i];
                    holdLeft[i] = int'($urandom_range(1, 16));
                end
                holdLeft[i]--;
            end
            prmDtHi = CW'($urandom_range(0, 12));
            prmDtLo = CW'($urandom_range(0, 12));
            ld = ($urandom_range(0, 39) == 0);
            cp = ($urandom_range(0, 24) == 0);
            if (faultN) fN = ($urandom_range(0, 299) != 0);
            else fN = ($urandom_range(0, 2) == 0);
            fc = ($urandom_range(0, 29) == 0);
            applyStimulus(cmd, ld, cp, fN, fc);
        end

        compareEn = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
